// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
//   Definitions shared by the SHA-256 message padder and sha_256_accelerator:
//   block/length geometry, the padder state encoding, the FIPS 180-4 initial
//   hash words H0..H7, the round-constant table K[0..63], and pad_mask(),
//   which selects the bytes the padder zeroes behind the 0x80 marker.
// ---------------------------------------------------------------------------
package sha256_pkg;

    localparam int BLOCK_W     = 512;
    localparam int LEN_FIELD_W = 64;
    localparam int BLOCK_BYTES = BLOCK_W / 8;                       // 64
    localparam int LEN_BYTES   = LEN_FIELD_W / 8;                   // 8
    localparam int LEN_BYTE0   = BLOCK_BYTES - LEN_BYTES;           // 56

    // Padder control states.
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_LEN  = 2'd2,
        ST_EMIT = 2'd3
    } pad_state_e;

    // Initial hash value H(0).
    localparam logic [31:0] H0 = 32'h6a09e667;
    localparam logic [31:0] H1 = 32'hbb67ae85;
    localparam logic [31:0] H2 = 32'h3c6ef372;
    localparam logic [31:0] H3 = 32'ha54ff53a;
    localparam logic [31:0] H4 = 32'h510e527f;
    localparam logic [31:0] H5 = 32'h9b05688c;
    localparam logic [31:0] H6 = 32'h1f83d9ab;
    localparam logic [31:0] H7 = 32'h5be0cd19;

    // Round constants.
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Byte-enable of the bytes that must be cleared behind the 0x80 marker
    // written at byte idx: bit b is set for every byte b > idx.
    function automatic logic [BLOCK_BYTES-1:0] pad_mask(input logic [6:0] idx);
        logic [BLOCK_BYTES-1:0] m;
        m = '0;
        for (int b = 0; b < BLOCK_BYTES; b++) begin
            m[b] = (32'(b) > 32'(idx));
        end
        return m;
    endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder
//   Packs a byte-stream message into 512-bit chunks and applies SHA-256
//   padding (message, 0x80, zero fill, 64-bit big-endian bit length).
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input byte handshake
//   in_data              message byte
//   in_keep              beat carries a byte (0 only legal with in_last, or
//                        as a no-op bubble)
//   in_last              beat ends the message
//   out_valid/out_ready  chunk handshake
//   out_block            chunk; byte 0 at [511:504]
//   out_first/out_last   chunk is first / final chunk of its message
// ---------------------------------------------------------------------------
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_keep,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block,
    output logic               out_first,
    output logic               out_last
);

    // Byte 0 of the chunk is element 0, which is the most significant byte of
    // the packed vector, so the buffer maps straight onto out_block.
    typedef logic [0:BLOCK_BYTES-1][7:0] chunk_buf_t;

    pad_state_e state_q, state_d;
    pad_state_e next_st_q, next_st_d;

    chunk_buf_t             buf_q, buf_d;
    logic [6:0]             idx_q, idx_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic                   first_q, first_d;
    logic                   out_first_q, out_first_d;
    logic                   out_last_q, out_last_d;

    logic                   accept;
    logic                   wr_byte;
    logic                   chunk_full;
    logic                   len_fits;
    logic [LEN_FIELD_W-1:0] len_be;
    logic [BLOCK_BYTES-1:0] pmask;

    assign accept     = in_valid && (state_q == ST_FILL);
    assign wr_byte    = accept && in_keep;
    assign chunk_full = wr_byte && (idx_q == 7'(BLOCK_BYTES - 1));
    // Room for the length field behind the 0x80 marker in the same chunk.
    assign len_fits   = (idx_q <= 7'(LEN_BYTE0 - 1));
    assign len_be     = LEN_FIELD_W'(len_q);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FILL;
            next_st_q <= ST_FILL;
        end else begin
            state_q   <= state_d;
            next_st_q <= next_st_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        next_st_d = next_st_q;
        unique case (state_q)
            ST_FILL: begin
                if (chunk_full) begin
                    // A message ending exactly on a chunk boundary still
                    // owes a padding chunk.
                    state_d   = ST_EMIT;
                    next_st_d = in_last ? ST_PAD : ST_FILL;
                end else if (accept && in_last) begin
                    state_d   = ST_PAD;
                end
            end
            ST_PAD: begin
                state_d   = ST_EMIT;
                next_st_d = len_fits ? ST_FILL : ST_LEN;
            end
            ST_LEN: begin
                state_d   = ST_EMIT;
                next_st_d = ST_FILL;
            end
            ST_EMIT: begin
                if (out_ready) state_d = next_st_q;
            end
            default: state_d = ST_FILL;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next-state
    // -----------------------------------------------------------------------
    always_comb begin
        buf_d       = buf_q;
        idx_d       = idx_q;
        len_d       = len_q;
        first_d     = first_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        pmask       = '0;

        unique case (state_q)
            ST_FILL: begin
                if (wr_byte) begin
                    buf_d[idx_q[5:0]] = in_data;
                    idx_d             = idx_q + 7'd1;
                    len_d             = len_q + LEN_W'(8);
                end
                if (chunk_full) begin
                    out_first_d = first_q;
                    out_last_d  = 1'b0;
                end
            end
            ST_PAD: begin
                pmask = pad_mask(idx_q);
                for (int b = 0; b < BLOCK_BYTES; b++) begin
                    if (pmask[b]) buf_d[6'(b)] = 8'h00;
                end
                buf_d[idx_q[5:0]] = 8'h80;
                if (len_fits) begin
                    for (int k = 0; k < LEN_BYTES; k++) begin
                        buf_d[6'(LEN_BYTE0 + k)] = len_be[LEN_FIELD_W - 8 - 8*k +: 8];
                    end
                end
                out_first_d = first_q;
                out_last_d  = len_fits;
            end
            ST_LEN: begin
                for (int b = 0; b < LEN_BYTE0; b++) begin
                    buf_d[6'(b)] = 8'h00;
                end
                for (int k = 0; k < LEN_BYTES; k++) begin
                    buf_d[6'(LEN_BYTE0 + k)] = len_be[LEN_FIELD_W - 8 - 8*k +: 8];
                end
                out_first_d = first_q;
                out_last_d  = 1'b1;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    // The chunk after a final chunk opens a new message.
                    first_d = out_last_q;
                    idx_d   = '0;
                    if ((next_st_q == ST_FILL) && out_last_q) begin
                        len_d = '0;
                        buf_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            first_q     <= 1'b1;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            first_q     <= first_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == ST_FILL);
        out_valid = (state_q == ST_EMIT);
        out_block = buf_q;
        out_first = out_first_q;
        out_last  = out_last_q;
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_keep, in_last;
    logic [7:0]   in_data;
    logic         out_valid, out_ready, out_first, out_last;
    logic [511:0] out_block;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } chunk_t;

    chunk_t exp_q[$];

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .out_first(out_first), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference: FIPS 180-4 padding of the whole message, then cut into
    // 64-byte chunks.
    task automatic build_expected(input byte unsigned msg[$]);
        byte unsigned p[$];
        longint unsigned bits;
        int nchunks;
        p    = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
        nchunks = p.size() / 64;
        for (int c = 0; c < nchunks; c++) begin
            chunk_t ch;
            ch.blk = '0;
            for (int b = 0; b < 64; b++) ch.blk[511 - 8*b -: 8] = p[c*64 + b];
            ch.first = (c == 0);
            ch.last  = (c == nchunks - 1);
            exp_q.push_back(ch);
        end
    endtask

    // Streams one message and checks every chunk it produces. stall holds
    // out_ready low for 10 cycles on each chunk; gaps inserts idle cycles,
    // keep=0 bubbles and random out_ready.
    task automatic run_msg(input byte unsigned msg[$], input bit stall, input bit gaps);
        int n, beats, bi, guard, lat_t, lat_d, hold_cnt;
        bit real_beat, acc;
        logic [511:0] held;
        chunk_t ch;
        n = msg.size();
        beats = (n == 0) ? 1 : n;
        bi = 0; guard = 0; lat_t = -1; lat_d = 2; hold_cnt = 0; held = '0;
        build_expected(msg);
        while ((bi < beats || exp_q.size() > 0) && guard < 5000) begin
            guard++;
            real_beat = 1'b0;
            if (bi < beats) begin
                if (gaps && $urandom_range(3) == 0) begin
                    in_valid = 1'($urandom_range(1));
                    in_keep  = 1'b0;
                    in_last  = 1'b0;
                    in_data  = 8'($urandom);
                end else begin
                    in_valid  = 1'b1;
                    in_keep   = (n != 0);
                    in_data   = (n != 0) ? msg[bi] : 8'($urandom);
                    in_last   = (bi == beats - 1);
                    real_beat = 1'b1;
                end
            end else begin
                in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
            end
            if (stall && out_valid && hold_cnt < 10) begin
                out_ready = 1'b0;
                if (hold_cnt == 0) held = out_block;
                else chk("stall_block_stable", out_block, held);
                hold_cnt++;
            end else begin
                out_ready = gaps ? 1'($urandom_range(1)) : 1'b1;
            end
            #1;
            if (out_valid) chk("in_ready_low_in_emit", 512'(in_ready), 512'(0));
            if (lat_t >= 0) begin
                if (lat_d == 2 && cyc == lat_t + 1) chk("latency_not_early", 512'(out_valid), 512'(0));
                if (cyc == lat_t + lat_d) begin
                    chk("latency_valid", 512'(out_valid), 512'(1));
                    lat_t = -1;
                end
            end
            if (out_valid && out_ready) begin
                hold_cnt = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_chunk", 512'(1), 512'(0));
                end else begin
                    ch = exp_q.pop_front();
                    chk("block", out_block, ch.blk);
                    chk("first", 512'(out_first), 512'(ch.first));
                    chk("last",  512'(out_last),  512'(ch.last));
                end
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc && real_beat) begin
                if (in_last) begin
                    lat_t = cyc;
                    lat_d = (n != 0 && (n % 64) == 0) ? 1 : 2;
                end
                bi++;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        chk("no_timeout", 512'(guard >= 5000), 512'(0));
        chk("all_chunks_seen", 512'(exp_q.size()), 512'(0));
        exp_q.delete();
    endtask

    initial begin
        byte unsigned m[$];
        int nmsg;
        rst = 1'b1;
        in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_out_block", out_block, 512'(0));
        chk("rst_out_first", 512'(out_first), 512'(0));
        chk("rst_out_last",  512'(out_last),  512'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        @(negedge clk);

        // "abc", compared against the known padded block as well.
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 1'b0, 1'b0);

        // empty message
        m = {};
        run_msg(m, 1'b0, 1'b0);

        // 55 and 56 bytes of 'A'
        m = {};
        repeat (55) m.push_back(8'h41);
        run_msg(m, 1'b0, 1'b0);
        m.push_back(8'h41);
        run_msg(m, 1'b0, 1'b0);

        // 64 bytes 0x00..0x3F
        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'(i));
        run_msg(m, 1'b0, 1'b0);

        // back-pressure on every chunk
        m = {};
        for (int i = 0; i < 130; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b1, 1'b0);

        // random back-to-back messages with bubbles and random out_ready
        for (int t = 0; t < 8; t++) begin
            nmsg = $urandom_range(200);
            if (t == 0) nmsg = 128;
            if (t == 1) nmsg = 61;
            m = {};
            for (int i = 0; i < nmsg; i++) m.push_back(8'($urandom));
            run_msg(m, t[0], 1'b1);
        end

        // reset in the middle of a message
        in_valid = 1'b1; in_keep = 1'b1; in_last = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; in_keep = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 512'(out_valid), 512'(0));
        chk("midrst_in_ready",  512'(in_ready), 512'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst_in_ready", 512'(in_ready), 512'(1));
        @(negedge clk);
        m = '{8'h61, 8'h62, 8'h63};
        build_expected(m);
        chk("abc_reference", exp_q[0].blk, {32'h61626380, 416'h0, 64'h18});
        exp_q.delete();
        run_msg(m, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
